// File: rtl/serial_bit_source_pkg.sv
// Shared constants for the serial bit source and the zero-detector benches.
// State encoding, default word width and default idle level.
package serial_bit_source_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   localparam int unsigned SER_WIDTH_DEF  = 8;
   localparam logic        IDLE_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit position counter for the serial source: clear, load, saturating
// increment, terminal-count flag at WIDTH-1.
module serial_bit_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          en_i,
   output logic [CW-1:0] cnt_o,
   output logic          tc_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tc;

   assign tc    = (cnt_q == CW'(WIDTH - 1));
   assign tc_o  = tc;
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && !tc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source feeding the zero detectors' x stream.
// Optional even parity bit after each word: define SERIAL_PARITY_EN.
module serial_bit_source
   import serial_bit_source_pkg::*;
#(
   parameter int unsigned WIDTH      = SER_WIDTH_DEF,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             x_q, x_d;
   logic             xv_q, xv_d;
   logic             done_q, done_d;
   logic             accept;
   logic             ld_head;
   logic [WIDTH-1:0] ld_rest;
   logic             sr_head;
   logic [WIDTH-1:0] sr_rest;
   logic             cnt_clr;
   logic             cnt_en;
   logic [CW-1:0]    cnt;
   logic             cnt_tc;
`ifdef SERIAL_PARITY_EN
   logic             par_q, par_d;
`endif

   assign load_ready = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign accept     = load_valid & load_ready;
   assign x          = x_q;
   assign x_valid    = xv_q;
   assign done       = done_q;

   // Head is the bit put on x now; rest is what stays queued behind it.
   assign ld_head = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
   assign ld_rest = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
   assign sr_head = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
   assign sr_rest = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);

   assign cnt_clr = (state_q == ST_IDLE) & ~accept;
   assign cnt_en  = (state_q == ST_SHIFT);

   serial_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .clk_i      (clock),
      .rst_ni     (reset),
      .clr_i      (cnt_clr),
      .load_i     (accept),
      .load_val_i ('0),
      .en_i       (cnt_en),
      .cnt_o      (cnt),
      .tc_o       (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      x_d     = x_q;
      xv_d    = xv_q;
      done_d  = 1'b0;
`ifdef SERIAL_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            x_d  = IDLE_LEVEL;
            xv_d = 1'b0;
            if (accept) begin
               state_d = ST_SHIFT;
               sr_d    = ld_rest;
               x_d     = ld_head;
               xv_d    = 1'b1;
`ifdef SERIAL_PARITY_EN
               par_d   = ^load_data;
`endif
            end
         end
         ST_SHIFT: begin
            if (cnt_tc) begin
`ifdef SERIAL_PARITY_EN
               state_d = ST_PARITY;
               x_d     = par_q;
               done_d  = 1'b1;
`else
               state_d = ST_IDLE;
               x_d     = IDLE_LEVEL;
               xv_d    = 1'b0;
`endif
            end else begin
               sr_d = sr_rest;
               x_d  = sr_head;
`ifndef SERIAL_PARITY_EN
               done_d = (cnt == CW'(WIDTH - 2));
`endif
            end
         end
`ifdef SERIAL_PARITY_EN
         ST_PARITY: begin
            state_d = ST_IDLE;
            x_d     = IDLE_LEVEL;
            xv_d    = 1'b0;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            x_d     = IDLE_LEVEL;
            xv_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         x_q     <= IDLE_LEVEL;
         xv_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
         done_q  <= done_d;
`ifdef SERIAL_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: MSB-first and LSB-first instances driven
// in parallel, checked every cycle against a per-word beat queue model.
module tb_serial_bit_source;

   localparam int W = 8;
`ifdef SERIAL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = W + PAR;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lv = 1'b0;
   logic [7:0] ld = 8'h00;

   logic m_rdy, m_x, m_xv, m_busy, m_done;
   logic l_rdy, l_x, l_xv, l_busy, l_done;

   serial_bit_source #(
      .WIDTH      (W),
      .MSB_FIRST  (1'b1),
      .IDLE_LEVEL (1'b1)
   ) dut_m (
      .clock      (clk),
      .reset      (rst_n),
      .load_valid (lv),
      .load_ready (m_rdy),
      .load_data  (ld),
      .x          (m_x),
      .x_valid    (m_xv),
      .busy       (m_busy),
      .done       (m_done)
   );

   serial_bit_source #(
      .WIDTH      (W),
      .MSB_FIRST  (1'b0),
      .IDLE_LEVEL (1'b1)
   ) dut_l (
      .clock      (clk),
      .reset      (rst_n),
      .load_valid (lv),
      .load_ready (l_rdy),
      .load_data  (ld),
      .x          (l_x),
      .x_valid    (l_xv),
      .busy       (l_busy),
      .done       (l_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(input string nm,
                               input logic [15:0] act,
                               input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endfunction

   // Model: each accepted word becomes a list of beats, one per bit cycle.
   typedef struct packed {
      logic x;
      logic done;
   } beat_t;

   beat_t q_m[$];
   beat_t q_l[$];
   bit    live = 1'b0;

   function automatic beat_t beat(input logic [7:0] d,
                                  input bit msb, input int i);
      beat_t b;
      if (i == W) b.x = ^d;
      else        b.x = msb ? d[W-1-i] : d[i];
      b.done = (i == NB - 1);
      return b;
   endfunction

   always @(posedge clk) begin
      live = 1'b1;
      if (!rst_n) begin
         q_m.delete();
         q_l.delete();
      end else if (q_m.size() == 0) begin
         if (lv) begin
            for (int i = 0; i < NB; i++) begin
               q_m.push_back(beat(ld, 1'b1, i));
               q_l.push_back(beat(ld, 1'b0, i));
            end
         end
      end else begin
         void'(q_m.pop_front());
         void'(q_l.pop_front());
      end
   end

   logic [4:0] em, el;

   // {x, x_valid, done, load_ready, busy}
   always @(negedge clk) begin
      if (live) begin
         if (q_m.size() != 0)
            em = {q_m[0].x, 1'b1, q_m[0].done, 1'b0, 1'b1};
         else
            em = 5'b10010;
         if (q_l.size() != 0)
            el = {q_l[0].x, 1'b1, q_l[0].done, 1'b0, 1'b1};
         else
            el = 5'b10010;
         chk("cycle msb", {m_x, m_xv, m_done, m_rdy, m_busy}, em);
         chk("cycle lsb", {l_x, l_xv, l_done, l_rdy, l_busy}, el);
      end
   end

   logic [8:0] xs_m, xs_l, dn;
   int         vcnt;

   // Starts on the negedge showing bit 0; ends on the first idle negedge.
   task automatic record();
      xs_m = '0;
      xs_l = '0;
      dn   = '0;
      vcnt = 0;
      for (int i = 0; i < NB; i++) begin
         xs_m[i] = m_x;
         xs_l[i] = l_x;
         dn[i]   = m_done;
         vcnt    = vcnt + int'(m_xv);
         @(negedge clk);
      end
   endtask

   task automatic run_word(input logic [7:0] d);
      lv = 1'b1;
      ld = d;
      @(negedge clk);
      lv = 1'b0;
      ld = ~d;
      record();
   endtask

   initial begin
      // Reset held with load_valid asserted
      rst_n = 1'b0;
      lv    = 1'b1;
      ld    = 8'hA5;
      repeat (3) begin
         @(negedge clk);
         chk("reset msb", {m_x, m_xv, m_rdy, m_done, m_busy}, 5'b10100);
         chk("reset lsb", {l_x, l_xv, l_rdy, l_done, l_busy}, 5'b10100);
      end
      rst_n = 1'b1;

      run_word(8'hA5);
      chk("A5 msb bits", 16'(xs_m[7:0]), 16'h00A5);
      chk("A5 lsb bits", 16'(xs_l[7:0]), 16'h00A5);
      chk("A5 done", 16'(dn), 16'(9'd1 << (NB - 1)));
      chk("A5 idle", {m_x, m_xv, m_rdy}, 3'b101);
`ifdef SERIAL_PARITY_EN
      chk("A5 parity", 16'(xs_m[8]), 16'h0000);
`endif

      run_word(8'h01);
      chk("01 lsb bits", 16'(xs_l[7:0]), 16'h0001);
      chk("01 msb bits", 16'(xs_m[7:0]), 16'h0080);
      chk("01 valid cnt", 16'(vcnt), 16'(NB));
      chk("01 idle", {l_x, l_xv, l_rdy}, 3'b101);

      // Second word requested while busy
      lv = 1'b1;
      ld = 8'h5A;
      @(negedge clk);
      ld = 8'h3C;
      chk("hold rdy", {m_rdy, l_rdy}, 2'b00);
      record();
      chk("5A lsb bits", 16'(xs_l[7:0]), 16'h005A);
      chk("5A msb bits", 16'(xs_m[7:0]), 16'h005A);
      chk("gap idle", {m_x, m_xv, m_rdy, m_busy}, 4'b1010);
      @(negedge clk);
      lv = 1'b0;
      ld = 8'h00;
      record();
      chk("3C lsb bits", 16'(xs_l[7:0]), 16'h003C);
      chk("3C msb bits", 16'(xs_m[7:0]), 16'h003C);

      // Reset in the middle of a word
      lv = 1'b1;
      ld = 8'h00;
      @(negedge clk);
      lv = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid bit3", {m_x, m_xv, m_busy}, 3'b011);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid rst", {m_x, m_xv, m_done, m_busy}, 4'b1000);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post rst", {l_x, l_xv, l_done, l_rdy}, 4'b1001);

      run_word(8'hFF);
      chk("FF msb bits", 16'(xs_m[7:0]), 16'h00FF);
      chk("FF lsb bits", 16'(xs_l[7:0]), 16'h00FF);
      chk("FF done", 16'(dn), 16'(9'd1 << (NB - 1)));

      run_word(8'h07);
`ifdef SERIAL_PARITY_EN
      chk("07 msb bits", 16'(xs_m), 16'h01E0);
      chk("07 lsb bits", 16'(xs_l), 16'h0107);
      chk("07 done", 16'(dn), 16'h0100);
`else
      chk("07 msb bits", 16'(xs_m[7:0]), 16'h00E0);
      chk("07 lsb bits", 16'(xs_l[7:0]), 16'h0007);
      chk("07 done", 16'(dn), 16'h0080);
`endif
      chk("07 valid cnt", 16'(vcnt), 16'(NB));

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
